// File: rtl/rrv64_l2_req_arb.sv
// Purpose: round-robin arbiter sharing the L2 request channel between L1I, L1D, PTW and ACP, with burst lock and outstanding limit.
// Latency: a beat accepted in cycle t is presented on l2_* in cycle t+1 through a one-entry output register.
// Backpressure: readies drop to zero while the output register is full and stalled, or when the outstanding limit is reached in IDLE.
module rrv64_l2_req_arb #(
    parameter int N_REQ     = 4,
    parameter int PLD_W     = 128,
    parameter int ID_W      = $clog2(N_REQ),
    parameter int MAX_OUTST = 8,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ*PLD_W-1:0] req_pld_i,
    input  logic [N_REQ-1:0]       req_last_i,
    output logic                   l2_valid_o,
    input  logic                   l2_ready_i,
    output logic [PLD_W-1:0]       l2_pld_o,
    output logic [ID_W-1:0]        l2_src_o,
    output logic                   l2_last_o,
    input  logic                   rsp_done_i,
    output logic [CNT_W-1:0]       outst_cnt_o,
    output logic                   busy_o
);

    localparam logic [0:0]       S_IDLE  = 1'b0;
    localparam logic [0:0]       S_LOCK  = 1'b1;
    localparam logic [N_REQ-1:0] ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  lk_q, lk_d;
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vld_q, vld_d;
    logic [PLD_W-1:0] pld_q, pld_d;
    logic [ID_W-1:0]  src_q, src_d;
    logic             last_q, last_d;

    logic             win_found;
    logic [ID_W-1:0]  win_idx;
    logic [ID_W-1:0]  cand_idx;
    logic             slot_free;
    logic             gnt_en;
    logic [ID_W-1:0]  gnt_idx;
    logic             accept;
    logic             idle_acc;
    logic             dec;

    // Round-robin search starting one past the last IDLE winner, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_idx = ID_W'((int'(rr_q) + i) % N_REQ);
            if (!win_found && req_valid_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Grant: the locked owner while a burst is open, otherwise the round-robin winner
    // gated by the registered outstanding count (a same-cycle rsp_done does not help).
    always_comb begin
        slot_free   = !vld_q || l2_ready_i;
        gnt_idx     = (state_q == S_LOCK) ? lk_q : win_idx;
        gnt_en      = (state_q == S_LOCK) ? slot_free
                                          : (win_found && (cnt_q < CNT_W'(MAX_OUTST)) && slot_free);
        req_ready_o = gnt_en ? (ONE_HOT << gnt_idx) : '0;
        accept      = gnt_en && req_valid_i[gnt_idx];
        idle_acc    = accept && (state_q == S_IDLE);
        dec         = rsp_done_i && (cnt_q != '0);
    end

    // Next-state for FSM, pointers, counter and output register.
    always_comb begin
        state_d = state_q;
        lk_d    = lk_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        pld_d   = pld_q;
        src_d   = src_q;
        last_d  = last_q;
        if (accept) begin
            vld_d  = 1'b1;
            pld_d  = req_pld_i[gnt_idx*PLD_W +: PLD_W];
            src_d  = gnt_idx;
            last_d = req_last_i[gnt_idx];
            if (state_q == S_IDLE) begin
                rr_d = gnt_idx;
                if (!req_last_i[gnt_idx]) begin
                    state_d = S_LOCK;
                    lk_d    = gnt_idx;
                end
            end else if (req_last_i[gnt_idx]) begin
                state_d = S_IDLE;
            end
        end else if (l2_ready_i) begin
            vld_d = 1'b0;
        end
        if (idle_acc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!idle_acc && dec) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Arbitration state: FSM, lock owner, round-robin pointer and outstanding count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lk_q    <= '0;
            rr_q    <= ID_W'(N_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lk_q    <= lk_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // One-entry output register toward L2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            pld_q  <= '0;
            src_q  <= '0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            pld_q  <= pld_d;
            src_q  <= src_d;
            last_q <= last_d;
        end
    end

    assign l2_valid_o  = vld_q;
    assign l2_pld_o    = pld_q;
    assign l2_src_o    = src_q;
    assign l2_last_o   = last_q;
    assign outst_cnt_o = cnt_q;
    assign busy_o      = (state_q == S_LOCK) || vld_q || (cnt_q != '0);

endmodule

// File: tb/tb_rrv64_l2_req_arb.sv
// Bench for rrv64_l2_req_arb: randomized requesters against a transaction-level reference model.
// Checks registered outputs once per cycle and combinational readies after inputs settle.
// Drives inputs on the falling edge; the DUT samples on the rising edge.
module tb_rrv64_l2_req_arb;

    localparam int N    = 4;
    localparam int W    = 128;
    localparam int MAXO = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid_i = '0;
    logic [N-1:0]   req_ready_o;
    logic [N*W-1:0] req_pld_i = '0;
    logic [N-1:0]   req_last_i = '0;
    logic           l2_valid_o;
    logic           l2_ready_i = 1'b0;
    logic [W-1:0]   l2_pld_o;
    logic [1:0]     l2_src_o;
    logic           l2_last_o;
    logic           rsp_done_i = 1'b0;
    logic [3:0]     outst_cnt_o;
    logic           busy_o;

    always #5 clk = ~clk;

    rrv64_l2_req_arb #(.N_REQ(N), .PLD_W(W), .MAX_OUTST(MAXO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_pld_i   (req_pld_i),
        .req_last_i  (req_last_i),
        .l2_valid_o  (l2_valid_o),
        .l2_ready_i  (l2_ready_i),
        .l2_pld_o    (l2_pld_o),
        .l2_src_o    (l2_src_o),
        .l2_last_o   (l2_last_o),
        .rsp_done_i  (rsp_done_i),
        .outst_cnt_o (outst_cnt_o),
        .busy_o      (busy_o)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side transaction generators.
    bit           act  [N];
    int           left [N];
    logic [W-1:0] cur  [N];
    int           beat_no = 0;

    // Reference model: who owns the channel (-1 = nobody), last winner, in-flight count,
    // and the beat L2 should currently see.
    int           m_lock;
    int           m_rr;
    int           m_cnt;
    bit           m_vld;
    logic [W-1:0] m_pld;
    int           m_src;
    bit           m_last;

    task automatic new_pld(input int k, output logic [W-1:0] p);
        logic [7:0] kb;
        beat_no++;
        kb = 8'(k);
        p  = {$urandom, $urandom, $urandom, 24'(beat_no), kb};
    endtask

    task automatic model_reset();
        m_lock = -1;
        m_rr   = N - 1;
        m_cnt  = 0;
        m_vld  = 0;
        m_pld  = '0;
        m_src  = 0;
        m_last = 0;
        for (int k = 0; k < N; k++) begin
            act[k]  = 0;
            left[k] = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_l2_valid"}, W'(l2_valid_o), '0);
        check({tag, "_l2_pld"},   l2_pld_o,       '0);
        check({tag, "_l2_src"},   W'(l2_src_o),   '0);
        check({tag, "_l2_last"},  W'(l2_last_o),  '0);
        check({tag, "_outst"},    W'(outst_cnt_o), '0);
        check({tag, "_busy"},     W'(busy_o),     '0);
        check({tag, "_ready"},    W'(req_ready_o), '0);
    endtask

    // One clock cycle of stimulus, model update and checking.
    task automatic cycle(input int p_req, input int p_rdy, input int p_rsp, input int max_len);
        logic [N-1:0] er;
        int  win, acc, j, old_cnt;
        bit  slot_free, lst, busy_exp;
        @(negedge clk);
        check("l2_valid", W'(l2_valid_o), W'(m_vld));
        if (m_vld) begin
            check("l2_pld",  l2_pld_o,       m_pld);
            check("l2_src",  W'(l2_src_o),   W'(m_src));
            check("l2_last", W'(l2_last_o),  W'(m_last));
        end
        check("outst_cnt", W'(outst_cnt_o), W'(m_cnt));
        busy_exp = (m_lock >= 0) || m_vld || (m_cnt != 0);
        check("busy", W'(busy_o), W'(busy_exp));

        for (int k = 0; k < N; k++) begin
            if (!act[k] && ($urandom_range(99) < p_req)) begin
                act[k]  = 1;
                left[k] = $urandom_range(1, max_len);
                new_pld(k, cur[k]);
            end
            req_valid_i[k]        = act[k];
            req_last_i[k]         = act[k] && (left[k] == 1);
            req_pld_i[k*W +: W]   = cur[k];
        end
        l2_ready_i = ($urandom_range(99) < p_rdy);
        rsp_done_i = ($urandom_range(99) < p_rsp) && (m_cnt > 0 || req_valid_i == '0);
        #1;

        slot_free = !m_vld || l2_ready_i;
        er  = '0;
        acc = -1;
        if (m_lock < 0) begin
            win = -1;
            for (int i = 1; i <= N; i++) begin
                j = (m_rr + i) % N;
                if (win < 0 && req_valid_i[j]) win = j;
            end
            if (win >= 0 && m_cnt < MAXO && slot_free) er[win] = 1'b1;
        end else begin
            er[m_lock] = slot_free;
        end
        check("req_ready", W'(req_ready_o), W'(er));

        for (int k = 0; k < N; k++)
            if (er[k] && req_valid_i[k]) acc = k;

        old_cnt = m_cnt;
        if (acc >= 0) begin
            lst    = req_last_i[acc];
            m_vld  = 1;
            m_pld  = cur[acc];
            m_src  = acc;
            m_last = lst;
            if (m_lock < 0) begin
                m_cnt++;
                m_rr = acc;
                if (!lst) m_lock = acc;
            end else if (lst) begin
                m_lock = -1;
            end
            left[acc]--;
            if (left[acc] == 0) act[acc] = 0;
            else new_pld(acc, cur[acc]);
        end else if (l2_ready_i) begin
            m_vld = 0;
        end
        if (rsp_done_i && old_cnt > 0) m_cnt--;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        req_valid_i = '0;
        req_last_i  = '0;
        req_pld_i   = '0;
        l2_ready_i  = 1'b0;
        rsp_done_i  = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        model_reset();
        #12;
        check_reset_outputs("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Underflow: rsp_done with nothing in flight and no requesters.
        cycle(0, 100, 100, 1);
        cycle(0, 100, 100, 1);

        // Single-beat round robin, all requesters valid.
        for (int i = 0; i < 12; i++) cycle(100, 100, 100, 1);

        // Bursts competing with single beats.
        for (int i = 0; i < 60; i++) cycle(100, 100, 60, 4);

        // Backpressure from L2.
        for (int i = 0; i < 200; i++) cycle(80, 40, 50, 4);

        // Outstanding limit: no retirements until saturated.
        for (int i = 0; i < 60; i++) cycle(100, 100, 0, 4);
        check("outst_saturated", W'(outst_cnt_o), W'(MAXO));
        for (int i = 0; i < 40; i++) cycle(100, 100, 20, 4);

        // Mixed random traffic.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(10, 100), $urandom_range(20, 100), $urandom_range(0, 60), 4);

        // Reset while a burst is open.
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            cycle(100, 100, 50, 4);
            if (m_lock >= 0) found = 1;
        end
        check("lock_seen_before_reset", W'(found), W'(1));
        do_reset();

        // After release requester 0 must win first.
        for (int i = 0; i < 8; i++) cycle(100, 100, 100, 1);
        for (int i = 0; i < 2000; i++)
            cycle($urandom_range(10, 100), $urandom_range(20, 100), $urandom_range(0, 60), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
